// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: memory-side responder for decode-stage load/store requests.
// One request at a time over valid/ready. After WAIT_CYCLES extra cycles the
// request is serviced against an internal RAM and a one-cycle rsp_valid strobe
// is returned. stall is high while a request is in flight.
//
// Optional feature: define MEM_BOUNDS_CHECK_EN to treat word addresses at or
// above MEM_DEPTH as out of range (err=1 with rsp_valid, store suppressed,
// load returns 0). Without the macro every 2**ADDR_W word is accessible and
// err stays 0.
//
// Handshake: a request transfers on a rising edge where req_valid & req_ready
// are both 1 and the request carries an op (load | mem_write). req_ready is 1
// only in IDLE; the requester holds its request while req_ready is 0. Requests
// with neither flag set are ignored and never produce a response.

module data_mem_ctrl #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 1,
    parameter int MEM_DEPTH   = 192
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              load,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              stall
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t            state;
    logic [3:0]        wait_cnt;
    logic              op_store_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    // RAM contents are deliberately not reset.
    logic [DATA_W-1:0] ram [2**ADDR_W];

    logic              accept;
    logic              acc_en;
    logic              acc_store;
    logic              acc_ok;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;

    assign req_ready = (state == ST_IDLE);
    assign stall     = ~req_ready;
    assign accept    = req_valid & req_ready & (load | mem_write);

    // Pick the access for this edge: with no wait the live request is used
    // directly at accept, otherwise the latched request when the count ends.
    always_comb begin
        acc_en    = 1'b0;
        acc_store = op_store_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        if (state == ST_IDLE) begin
            acc_en    = accept && (WAIT_CYCLES == 0);
            acc_store = mem_write;
            acc_addr  = addr;
            acc_wdata = wdata;
        end else if (state == ST_WAIT) begin
            acc_en = (wait_cnt == 4'd1);
        end
    end

`ifdef MEM_BOUNDS_CHECK_EN
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(MEM_DEPTH);
    assign acc_ok = ({1'b0, acc_addr} < DEPTH_LIM);
`else
    assign acc_ok = 1'b1;
`endif

    // RAM write port; held off during reset so an aborted store never lands.
    always_ff @(posedge clk) begin
        if (rst_n && acc_en && acc_store && acc_ok) begin
            ram[acc_addr] <= acc_wdata;
        end
    end

    // Request FSM with registered response, error and read-data outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            wait_cnt   <= 4'd0;
            op_store_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rsp_valid  <= 1'b0;
            rdata      <= '0;
            err        <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            err       <= 1'b0;
            if (acc_en) begin
                rsp_valid <= 1'b1;
                err       <= ~acc_ok;
                if (!acc_store) begin
                    rdata <= acc_ok ? ram[acc_addr] : '0;
                end
            end
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_store_q <= mem_write;
                        addr_q     <= addr;
                        wdata_q    <= wdata;
                        if (WAIT_CYCLES == 0) begin
                            state <= ST_RESP;
                        end else begin
                            wait_cnt <= WAIT_INIT;
                            state    <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        state <= ST_RESP;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Testbench for data_mem_ctrl. Two instances (WAIT_CYCLES 0 and 3) run side by
// side with independent request inputs and a shared clock/reset. A behavioural
// model per instance tracks cycles since accept, a word array and the last
// load result; a negedge process compares every output each cycle.

module tb_data_mem_ctrl;

    localparam int DW = 16;
    localparam int AW = 8;
    localparam int W0 = 0;
    localparam int W1 = 3;

    int wc [2] = '{W0, W1};

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          rv    [2];
    logic          ld_i  [2];
    logic          st_i  [2];
    logic [AW-1:0] ad_i  [2];
    logic [DW-1:0] wd_i  [2];
    logic          req_ready [2];
    logic          rsp_valid [2];
    logic [DW-1:0] rdata     [2];
    logic          err       [2];
    logic          stall     [2];

    data_mem_ctrl #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYCLES(W0), .MEM_DEPTH(192)) dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv[0]), .req_ready(req_ready[0]),
        .load(ld_i[0]), .mem_write(st_i[0]), .addr(ad_i[0]), .wdata(wd_i[0]),
        .rsp_valid(rsp_valid[0]), .rdata(rdata[0]), .err(err[0]), .stall(stall[0])
    );

    data_mem_ctrl #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYCLES(W1), .MEM_DEPTH(192)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv[1]), .req_ready(req_ready[1]),
        .load(ld_i[1]), .mem_write(st_i[1]), .addr(ad_i[1]), .wdata(wd_i[1]),
        .rsp_valid(rsp_valid[1]), .rdata(rdata[1]), .err(err[1]), .stall(stall[1])
    );

    // ---------------- scoreboard bookkeeping ----------------
    int checks = 0;
    int errors = 0;
    bit model_on = 1'b0;

    function automatic void chk(input string name, input int k,
                                input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d: got %h expected %h at %0t", name, k, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    // p = cycles elapsed since accept (-1 when idle). The response is visible
    // while p == W; the controller is idle again once p reaches W+1.
    int            p      [2];
    logic          m_st   [2];
    logic [AW-1:0] m_ad   [2];
    logic [DW-1:0] m_wd   [2];
    logic [DW-1:0] m_rd   [2];
    logic          m_oob  [2];
    logic [DW-1:0] mem    [2][256];
    logic [DW-1:0] exp_q  [$];

    function automatic bit out_of_range(input logic [AW-1:0] a);
`ifdef MEM_BOUNDS_CHECK_EN
        return int'(a) >= 192;
`else
        return 1'b0;
`endif
    endfunction

    task automatic m_access(input int k);
        if (m_st[k]) begin
            if (!m_oob[k]) mem[k][m_ad[k]] = m_wd[k];
        end else begin
            m_rd[k] = m_oob[k] ? '0 : mem[k][m_ad[k]];
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                p[k]     = -1;
                m_rd[k]  = '0;
                m_oob[k] = 1'b0;
            end else if (p[k] < 0) begin
                if (rv[k] && (ld_i[k] || st_i[k])) begin
                    m_st[k]  = st_i[k];
                    m_ad[k]  = ad_i[k];
                    m_wd[k]  = wd_i[k];
                    m_oob[k] = out_of_range(ad_i[k]);
                    p[k]     = 0;
                    if (wc[k] == 0) m_access(k);
                end
            end else begin
                p[k] = p[k] + 1;
                if (p[k] == wc[k] + 1) p[k] = -1;
                else if (p[k] == wc[k]) m_access(k);
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (model_on) begin
            for (int k = 0; k < 2; k++) begin
                chk("cyc_req_ready", k, 32'(req_ready[k]), 32'(p[k] < 0));
                chk("cyc_stall",     k, 32'(stall[k]),     32'(p[k] >= 0));
                chk("cyc_rsp_valid", k, 32'(rsp_valid[k]), 32'(p[k] == wc[k]));
                chk("cyc_err",       k, 32'(err[k]),       32'((p[k] == wc[k]) && m_oob[k]));
                chk("cyc_rdata",     k, 32'(rdata[k]),     32'(m_rd[k]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle_inputs(input int k);
        rv[k] = 1'b0; ld_i[k] = 1'b0; st_i[k] = 1'b0; ad_i[k] = '0; wd_i[k] = '0;
    endtask

    // Issue one request on instance k, hold until accepted, then wait for the
    // response. Checks latency and that the controller is ready the cycle after.
    task automatic do_req(input int k, input logic l, input logic s,
                          input logic [AW-1:0] a, input logic [DW-1:0] d,
                          output logic [DW-1:0] rd, output logic e);
        bit acc;
        int lat;
        rd = '0; e = 1'b0; acc = 1'b0; lat = 0;
        rv[k] = 1'b1; ld_i[k] = l; st_i[k] = s; ad_i[k] = a; wd_i[k] = d;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            acc = req_ready[k];
            @(posedge clk);
            #1;
            if (acc) break;
        end
        idle_inputs(k);
        if (!acc) begin
            chk("accept_timeout", k, 32'd0, 32'd1);
        end else begin
            for (int i = 1; i <= 40; i++) begin
                @(negedge clk);
                if (rsp_valid[k]) begin
                    lat = i;
                    rd  = rdata[k];
                    e   = err[k];
                    break;
                end
            end
            chk("latency", k, 32'(lat), 32'(wc[k] + 1));
            @(negedge clk);
            chk("ready_after_resp", k, 32'(req_ready[k]), 32'd1);
        end
    endtask

    // ---------------- stimulus ----------------
    logic [DW-1:0] init_val [256];
    logic [DW-1:0] rd;
    logic          e;
    int            cnt;
    int            idx [2];

    initial begin
        for (int k = 0; k < 2; k++) idle_inputs(k);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        model_on = 1'b1;
        for (int k = 0; k < 2; k++) begin
            chk("reset_req_ready", k, 32'(req_ready[k]), 32'd1);
            chk("reset_rsp_valid", k, 32'(rsp_valid[k]), 32'd0);
            chk("reset_rdata",     k, 32'(rdata[k]),     32'd0);
            chk("reset_err",       k, 32'(err[k]),       32'd0);
            chk("reset_stall",     k, 32'(stall[k]),     32'd1 - 32'd1);
        end
        rst_n = 1'b1;

        // Fill the RAM of both instances with known values.
        for (int i = 0; i < 256; i++) begin
            init_val[i] = 16'($urandom);
            for (int k = 0; k < 2; k++) do_req(k, 1'b0, 1'b1, 8'(i), init_val[i], rd, e);
        end

        for (int k = 0; k < 2; k++) begin
            // Store then load.
            do_req(k, 1'b0, 1'b1, 8'h10, 16'hBEEF, rd, e);
            chk("store_err", k, 32'(e), 32'd0);
            do_req(k, 1'b1, 1'b0, 8'h10, 16'h0000, rd, e);
            chk("load_beef", k, 32'(rd), 32'hBEEF);
            chk("load_err",  k, 32'(e), 32'd0);

            // Both flags set is a store; rdata must keep the last load value.
            do_req(k, 1'b1, 1'b1, 8'h05, 16'h1234, rd, e);
            chk("prio_rdata_hold", k, 32'(rd), 32'hBEEF);
            do_req(k, 1'b1, 1'b0, 8'h05, 16'h0000, rd, e);
            chk("prio_load", k, 32'(rd), 32'h1234);

            // Bounds behaviour at word 0xC0.
            do_req(k, 1'b0, 1'b1, 8'hC0, 16'hABCD, rd, e);
`ifdef MEM_BOUNDS_CHECK_EN
            chk("bounds_store_err", k, 32'(e), 32'd1);
            chk("bounds_store_rd",  k, 32'(rd), 32'h1234);
            do_req(k, 1'b1, 1'b0, 8'hC0, 16'h0000, rd, e);
            chk("bounds_load_rd",  k, 32'(rd), 32'h0000);
            chk("bounds_load_err", k, 32'(e), 32'd1);
`else
            chk("bounds_store_err", k, 32'(e), 32'd0);
            do_req(k, 1'b1, 1'b0, 8'hC0, 16'h0000, rd, e);
            chk("bounds_load_rd",  k, 32'(rd), 32'hABCD);
            chk("bounds_load_err", k, 32'(e), 32'd0);
`endif
        end

        // No-op requests never respond.
        cnt = 0;
        for (int k = 0; k < 2; k++) begin
            rv[k] = 1'b1; ld_i[k] = 1'b0; st_i[k] = 1'b0; ad_i[k] = 8'h33;
        end
        repeat (6) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) cnt += int'(rsp_valid[k]);
        end
        chk("noop_rsp_count", 0, 32'(cnt), 32'd0);
        for (int k = 0; k < 2; k++) idle_inputs(k);

        // A request held while busy is taken only after the IDLE bubble.
        idx[0] = -1; idx[1] = -1;
        rv[1] = 1'b1; ld_i[1] = 1'b1; ad_i[1] = 8'h10;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (rsp_valid[1]) begin
                if (idx[0] < 0) idx[0] = c;
                else if (idx[1] < 0) idx[1] = c;
            end
        end
        idle_inputs(1);
        chk("busy_gap", 1, 32'(idx[1] - idx[0]), 32'(W1 + 2));
        repeat (W1 + 3) @(negedge clk);

        // Reset during WAIT aborts the pending store.
        rv[1] = 1'b1; st_i[1] = 1'b1; ad_i[1] = 8'h20; wd_i[1] = 16'h5555;
        @(posedge clk);
        #1;
        idle_inputs(1);
        @(posedge clk);
        #1;
        chk("midop_stall", 1, 32'(stall[1]), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_rsp_valid", 1, 32'(rsp_valid[1]), 32'd0);
        chk("abort_req_ready", 1, 32'(req_ready[1]), 32'd1);
        chk("abort_stall",     1, 32'(stall[1]),     32'd0);
        chk("abort_rdata",     1, 32'(rdata[1]),     32'd0);
        chk("abort_err",       1, 32'(err[1]),       32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            cnt += int'(rsp_valid[1]);
        end
        chk("abort_no_rsp", 1, 32'(cnt), 32'd0);
        exp_q.push_back(init_val[8'h20]);
        do_req(1, 1'b1, 1'b0, 8'h20, 16'h0000, rd, e);
        chk("abort_prior_word", 1, 32'(rd), 32'(exp_q.pop_front()));

        // Randomized traffic with occasional resets; the model checks each cycle.
        repeat (3000) begin
            @(posedge clk);
            #1;
            rst_n = ($urandom_range(0, 299) != 0);
            for (int k = 0; k < 2; k++) begin
                rv[k]   = 1'($urandom_range(0, 1));
                ld_i[k] = 1'($urandom_range(0, 1));
                st_i[k] = ($urandom_range(0, 2) == 0);
                ad_i[k] = 8'($urandom);
                wd_i[k] = 16'($urandom);
            end
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) idle_inputs(k);
        repeat (10) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
